instr_fetch: RTL and testbench

Instruction fetch stage for the single-cycle ARMv4 message-decoder core. Holds the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and presents each instruction to decode and the immediate extender, which receives instr[23:0]. It consumes the extender's branch immediate to compute the next PC. It also exports the R15 read value (PC+8).

---
 rtl/instr_fetch_if.sv | 33 +++
 rtl/instr_fetch.sv | 66 ++++++
 tb/tb_instr_fetch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port plus the decode-side instruction handshake.
// master = fetch stage, slave = memory/decode environment.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] ext_imm;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pcplus8;
  logic [15:0] retired;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr, instr_valid,
    input  instr_ready, branch_taken, ext_imm, halt,
    output pc, pcplus8, retired
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr, instr_valid,
    output instr_ready, branch_taken, ext_imm, halt,
    input  pc, pcplus8, retired
  );
endinterface

// File: rtl/instr_fetch.sv
// ARMv4 fetch stage: PC, req/ack fetch, held instruction; min 2 cycles/instr (FETCH+HOLD), +1 per memory wait.
// instr_ready low holds instr/pc/retired in HOLD; halt blocks new fetches but lets an in-flight fetch finish.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {START, FETCH, HOLD, HALTED} state_t;

  state_t      state, nextState;
  logic [31:0] pcReg, instrReg, nextPc, branchTarget;
  logic [15:0] retiredCnt;
  logic        consume;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= START;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    consume   = 1'b0;
    case (state)
      START:  nextState = bus.halt ? HALTED : FETCH;
      FETCH:  if (bus.imem_ack) nextState = HOLD;
      HOLD: begin
        if (bus.instr_ready) begin
          consume   = 1'b1;
          nextState = bus.halt ? HALTED : FETCH;
        end
      end
      HALTED: if (!bus.halt) nextState = FETCH;
      default: nextState = START;
    endcase
  end

  // Branch target is relative to R15 (pc+8); low bits forced so imem_addr stays word aligned.
  assign branchTarget = pcReg + 32'd8 + bus.ext_imm;
  assign nextPc       = bus.branch_taken ? {branchTarget[31:2], 2'b00} : pcReg + 32'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcReg      <= RESET_PC;
      instrReg   <= 32'h0;
      retiredCnt <= 16'h0;
    end else begin
      if (state == FETCH && bus.imem_ack) instrReg <= bus.imem_rdata;
      if (consume) begin
        pcReg      <= nextPc;
        retiredCnt <= retiredCnt + 16'd1;
      end
    end
  end

  assign bus.imem_req    = (state == FETCH);
  assign bus.imem_addr   = {pcReg[31:2], 2'b00};
  assign bus.instr       = instrReg;
  assign bus.instr_valid = (state == HOLD);
  assign bus.pc          = pcReg;
  assign bus.pcplus8     = pcReg + 32'd8;
  assign bus.retired     = retiredCnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table of fetch transactions plus reset, halt and stray-ack sequences.
module tb_instr_fetch;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          waits;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] imm;
    int          stall;
    logic [31:0] addr;
    logic [15:0] retAfter;
  } txn_t;

  txn_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called on a negedge with the DUT in FETCH; returns on a negedge after the consuming edge.
  task automatic runTxn(input txn_t t);
    logic [15:0] retBefore;
    retBefore = t.retAfter - 16'd1;
    for (int w = 0; w <= t.waits; w++) begin
      chk("fetch_req", {31'h0, bus.imem_req}, 32'h1);
      chk("fetch_addr", bus.imem_addr, t.addr);
      chk("fetch_valid", {31'h0, bus.instr_valid}, 32'h0);
      bus.imem_ack   = (w == t.waits);
      bus.imem_rdata = (w == t.waits) ? t.rdata : 32'hBAD0_0BAD;
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    for (int d = 0; d <= t.stall; d++) begin
      chk("hold_valid", {31'h0, bus.instr_valid}, 32'h1);
      chk("hold_req", {31'h0, bus.imem_req}, 32'h0);
      chk("hold_instr", bus.instr, t.rdata);
      chk("hold_pc", bus.pc, t.addr);
      chk("hold_pcplus8", bus.pcplus8, t.addr + 32'd8);
      chk("hold_retired", {16'h0, bus.retired}, {16'h0, retBefore});
      bus.instr_ready  = (d == t.stall);
      bus.branch_taken = (d == t.stall) ? t.br : 1'b0;
      bus.ext_imm      = (d == t.stall) ? t.imm : 32'hFFFF_FFF0;
      @(negedge clk);
    end
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    bus.ext_imm      = 32'h0;
    chk("retired_after", {16'h0, bus.retired}, {16'h0, t.retAfter});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //         waits rdata          br    imm            stall addr           ret
    tbl[0]  = '{0, 32'hE3A0_1005, 1'b0, 32'h0,          0, 32'h0000_0000, 16'd1};
    tbl[1]  = '{3, 32'h1111_1111, 1'b0, 32'h0,          0, 32'h0000_0004, 16'd2};
    tbl[2]  = '{3, 32'h2222_2222, 1'b0, 32'h0,          5, 32'h0000_0008, 16'd3};
    tbl[3]  = '{3, 32'h3333_3333, 1'b0, 32'h0,          0, 32'h0000_000C, 16'd4};
    tbl[4]  = '{1, 32'hEA00_003A, 1'b1, 32'h0000_00E8,  0, 32'h0000_0010, 16'd5};
    tbl[5]  = '{0, 32'hEA11_A013, 1'b1, 32'h0046_804C,  0, 32'h0000_0100, 16'd6};
    tbl[6]  = '{2, 32'hEAF6_5FA9, 1'b1, 32'hFFD9_7EA4,  1, 32'h0046_8154, 16'd7};
    tbl[7]  = '{0, 32'hEAF8_2A93, 1'b1, 32'hFFE0_AA4C,  0, 32'h0020_0000, 16'd8};
    tbl[8]  = '{0, 32'hEAFF_D568, 1'b1, 32'hFFFF_55A0,  0, 32'h0000_AA54, 16'd9};
    tbl[9]  = '{1, 32'hE1A0_0000, 1'b0, 32'h0,          0, 32'hFFFF_FFFC, 16'd10};
    tbl[10] = '{0, 32'hE280_0001, 1'b0, 32'h0,          0, 32'h0000_0000, 16'd11};

    reset            = 1'b0;
    bus.imem_ack     = 1'b1;
    bus.imem_rdata   = 32'hDEAD_BEEF;
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    bus.ext_imm      = 32'h0;
    bus.halt         = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'h0, bus.imem_req}, 32'h0);
    chk("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_pcplus8", bus.pcplus8, 32'h8);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_retired", {16'h0, bus.retired}, 32'h0);

    // Release with a stray ack still high: START must ignore it.
    reset = 1'b1;
    #1;
    chk("e0_req", {31'h0, bus.imem_req}, 32'h0);
    @(negedge clk);
    chk("e1_valid", {31'h0, bus.instr_valid}, 32'h0);
    bus.imem_ack = 1'b0;

    foreach (tbl[i]) runTxn(tbl[i]);

    // Halt raised mid-fetch: word still delivered, then HALTED with pc at next address.
    bus.halt = 1'b1;
    runTxn('{2, 32'h4444_4444, 1'b0, 32'h0, 0, 32'h0000_0004, 16'd12});
    for (int i = 0; i < 3; i++) begin
      chk("halted_req", {31'h0, bus.imem_req}, 32'h0);
      chk("halted_valid", {31'h0, bus.instr_valid}, 32'h0);
      chk("halted_pc", bus.pc, 32'h0000_0008);
      bus.imem_ack = (i == 1);
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    chk("halted_instr", bus.instr, 32'h4444_4444);
    bus.halt = 1'b0;
    @(negedge clk);
    chk("resume_req", {31'h0, bus.imem_req}, 32'h1);
    chk("resume_addr", bus.imem_addr, 32'h0000_0008);

    // Reset asserted mid-FETCH takes effect without a clock edge.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_req", {31'h0, bus.imem_req}, 32'h0);
    chk("midrst_pc", bus.pc, 32'h0);
    chk("midrst_retired", {16'h0, bus.retired}, 32'h0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hFEED_FACE;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("stray_req", {31'h0, bus.imem_req}, 32'h1);
    chk("stray_valid", {31'h0, bus.instr_valid}, 32'h0);
    chk("stray_instr", bus.instr, 32'h0);
    bus.imem_ack = 1'b0;
    runTxn('{0, 32'h5555_5555, 1'b0, 32'h0, 0, 32'h0000_0000, 16'd1});
    chk("final_addr", bus.imem_addr, 32'h0000_0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
